// File: rtl/fetch_mem_unit.sv
// Fetch/memory-access unit: owns PC, IR, link/return storage and the shared memory port.
// Define FETCH_RAS_EN to replace the single link register with a RAS_DEPTH-entry return stack.
//
// state   | meaning
// S_IDLE  | no access; sample halt > data_req > fetch_req, apply branches
// S_FETCH | read at pc until mem_ready, then load ir and advance pc
// S_DATA  | load/store at latched address until mem_ready
// S_HALTED| inert until reset
module fetch_mem_unit #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic              br_take,
    input  logic [1:0]        br_mode,
    input  logic [DATA_W-1:0] br_offset,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              halt,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_done,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DATA, S_HALTED} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] d_addr;
    logic              d_we;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] rel_pc;
    logic [ADDR_W-1:0] ret_pc;
    logic              br_now, call_now, fetch_done, data_fin, data_start;
    logic              unused_offset_hi;

    if (RAS_DEPTH < 1) begin : g_ras_depth_check
        $error("RAS_DEPTH must be at least 1");
    end

    assign unused_offset_hi = ^br_offset[DATA_W-1:ADDR_W];

    assign br_now     = (state == S_IDLE) && br_take;
    assign call_now   = br_now && (br_mode == 2'b10);
    assign fetch_done = (state == S_FETCH) && mem_ready;
    assign data_fin   = (state == S_DATA) && mem_ready;
    assign data_start = (state == S_IDLE) && !halt && data_req;
    assign rel_pc     = pc + br_offset[ADDR_W-1:0];
    assign busy       = (state == S_FETCH) || (state == S_DATA);
    assign halted     = (state == S_HALTED);

    always_comb begin
        state_nxt = state;
        mem_cmd   = 2'b00;
        mem_addr  = pc;
        case (state)
            S_IDLE: begin
                if (halt)           state_nxt = S_HALTED;
                else if (data_req)  state_nxt = S_DATA;
                else if (fetch_req) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_cmd = 2'b01;
                if (mem_ready) state_nxt = S_IDLE;
            end
            S_DATA: begin
                mem_cmd  = d_we ? 2'b10 : 2'b01;
                mem_addr = d_addr;
                if (mem_ready) state_nxt = S_IDLE;
            end
            S_HALTED: state_nxt = S_HALTED;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Branches only happen in IDLE, fetch completion only in FETCH, so they never collide.
    always_comb begin
        pc_nxt = pc;
        if (fetch_done) begin
            pc_nxt = pc + 1'b1;
        end else if (br_now) begin
            case (br_mode)
                2'b00:   pc_nxt = rel_pc;
                2'b01:   pc_nxt = br_target;
                2'b10:   pc_nxt = rel_pc;
                default: pc_nxt = ret_pc;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            ir         <= '0;
            ir_valid   <= 1'b0;
            data_rdata <= '0;
            data_done  <= 1'b0;
            d_addr     <= '0;
            d_we       <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            ir_valid  <= fetch_done;
            data_done <= data_fin;
            if (fetch_done) ir <= mem_rdata;
            if (data_fin && !d_we) data_rdata <= mem_rdata;
            if (data_start) begin
                d_addr    <= data_addr;
                d_we      <= data_we;
                mem_wdata <= data_wdata;
            end
        end
    end

`ifdef FETCH_RAS_EN
    // Entry 0 is the top; vacated slots refill with RESET_PC so an empty pop yields it.
    logic              ret_now;
    logic [ADDR_W-1:0] ras [RAS_DEPTH];

    assign ret_now = br_now && (br_mode == 2'b11);
    assign ret_pc  = ras[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) ras[i] <= RESET_PC;
        end else if (call_now) begin
            ras[0] <= pc;
            for (int i = 1; i < RAS_DEPTH; i++) ras[i] <= ras[i-1];
        end else if (ret_now) begin
            for (int i = 0; i < RAS_DEPTH - 1; i++) ras[i] <= ras[i+1];
            ras[RAS_DEPTH-1] <= RESET_PC;
        end
    end
`else
    logic [ADDR_W-1:0] link;

    assign ret_pc = link;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         link <= RESET_PC;
        else if (call_now) link <= pc;
    end
`endif

endmodule

// File: tb/tb_fetch_mem_unit.sv
// Scoreboard bench for fetch_mem_unit: a latency-programmable memory model, a pulse monitor
// popping expected ir/load/store results, and directed stimulus with hand-computed values.
module tb_fetch_mem_unit;
    localparam int AW = 9;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fetch_req = 1'b0, data_req = 1'b0, data_we = 1'b0;
    logic [AW-1:0] data_addr = '0;
    logic [DW-1:0] data_wdata = '0;
    logic          br_take = 1'b0;
    logic [1:0]    br_mode = 2'b00;
    logic [DW-1:0] br_offset = '0;
    logic [AW-1:0] br_target = '0;
    logic          halt = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic [1:0]    mem_cmd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] ir;
    logic          ir_valid;
    logic [DW-1:0] data_rdata;
    logic          data_done;
    logic [AW-1:0] pc;
    logic          busy;
    logic          halted;

    fetch_mem_unit dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .data_req(data_req),
        .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .br_take(br_take), .br_mode(br_mode), .br_offset(br_offset), .br_target(br_target),
        .halt(halt), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_cmd(mem_cmd),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .ir(ir), .ir_valid(ir_valid),
        .data_rdata(data_rdata), .data_done(data_done), .pc(pc), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          is_store;
        logic [AW-1:0] addr;
        logic [DW-1:0] val;
    } data_exp_t;

    logic [DW-1:0] exp_ir_q[$];
    data_exp_t     exp_data_q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            wait_cycles = 0;
    int            wait_cnt = 0;
    logic [AW-1:0] last_wr_addr = '0;
    logic [DW-1:0] last_wr_data = '0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        case (a)
            9'h000:  return 16'hD105;
            9'h014:  return 16'h00AB;
            default: return 16'hA000 | {7'h00, a};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Memory model: completes an access after wait_cycles stalled cycles.
    always @(negedge clk) begin
        if (mem_cmd != 2'b00) begin
            if (wait_cnt >= wait_cycles) begin
                mem_ready = 1'b1;
                mem_rdata = mem_word(mem_addr);
                if (mem_cmd == 2'b10) begin
                    last_wr_addr = mem_addr;
                    last_wr_data = mem_wdata;
                end
                wait_cnt = 0;
            end else begin
                mem_ready = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ready = 1'b0;
            wait_cnt = 0;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT pulses a completion.
    always @(negedge clk) begin
        if (!reset) begin
            check("cmd_legal", {31'd0, mem_cmd == 2'b11}, 32'd0);
            check("pulse_excl", {31'd0, ir_valid & data_done}, 32'd0);
            if (ir_valid) begin
                if (exp_ir_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL ir_unexpected: got ir_valid with ir=%0h, expected none", ir);
                end else begin
                    check("ir", {16'd0, ir}, {16'd0, exp_ir_q.pop_front()});
                end
            end
            if (data_done) begin
                if (exp_data_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL data_unexpected: got data_done, expected none");
                end else begin
                    data_exp_t e;
                    e = exp_data_q.pop_front();
                    if (e.is_store) begin
                        check("st_addr", {23'd0, last_wr_addr}, {23'd0, e.addr});
                        check("st_data", {16'd0, last_wr_data}, {16'd0, e.val});
                    end else begin
                        check("ld_data", {16'd0, data_rdata}, {16'd0, e.val});
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_fetch(input logic [DW-1:0] exp);
        tick();
        fetch_req = 1'b1;
        exp_ir_q.push_back(exp);
        tick();
        fetch_req = 1'b0;
        wait_idle("fetch_timeout");
    endtask

    task automatic do_branch(input logic [1:0] mode, input logic [DW-1:0] off,
                             input logic [AW-1:0] tgt);
        tick();
        br_take = 1'b1; br_mode = mode; br_offset = off; br_target = tgt;
        tick();
        br_take = 1'b0;
    endtask

    task automatic do_load(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        data_exp_t e;
        e.is_store = 1'b0; e.addr = a; e.val = exp;
        tick();
        data_req = 1'b1; data_we = 1'b0; data_addr = a;
        exp_data_q.push_back(e);
        tick();
        data_req = 1'b0;
        wait_idle("load_timeout");
    endtask

    task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] v);
        data_exp_t e;
        e.is_store = 1'b1; e.addr = a; e.val = v;
        tick();
        data_req = 1'b1; data_we = 1'b1; data_addr = a; data_wdata = v;
        exp_data_q.push_back(e);
        tick();
        data_req = 1'b0; data_we = 1'b0;
        check("st_cmd", {30'd0, mem_cmd}, 32'd2);
        check("st_port_addr", {23'd0, mem_addr}, {23'd0, a});
        check("st_port_wdata", {16'd0, mem_wdata}, {16'd0, v});
        wait_idle("store_timeout");
    endtask

    logic [AW-1:0] exp_ret [5];

    initial begin
        // Reset state
        tick(); tick();
        check("rst_pc", {23'd0, pc}, 32'd0);
        check("rst_cmd", {30'd0, mem_cmd}, 32'd0);
        check("rst_ir", {16'd0, ir}, 32'd0);
        check("rst_flags", {28'd0, busy, halted, ir_valid, data_done}, 32'd0);
        reset = 1'b0;

        // Minimum-latency fetch: ir_valid in the second cycle after the sampling edge
        tick();
        fetch_req = 1'b1;
        exp_ir_q.push_back(16'hD105);
        tick();
        fetch_req = 1'b0;
        @(negedge clk);
        check("lat_n1_valid", {31'd0, ir_valid}, 32'd0);
        check("lat_n1_cmd", {30'd0, mem_cmd}, 32'd1);
        @(negedge clk);
        check("lat_n2_valid", {31'd0, ir_valid}, 32'd1);
        check("fetch1_pc", {23'd0, pc}, 32'd1);

        // Fetch with three stall cycles
        wait_cycles = 3;
        tick();
        fetch_req = 1'b1;
        exp_ir_q.push_back(16'hA001);
        tick();
        fetch_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("stall_cmd", {30'd0, mem_cmd}, 32'd1);
            check("stall_addr", {23'd0, mem_addr}, 32'd1);
        end
        @(negedge clk);
        check("stall_done", {31'd0, busy}, 32'd0);
        check("fetch2_pc", {23'd0, pc}, 32'd2);

        // Load then store
        wait_cycles = 1;
        do_load(9'h014, 16'h00AB);
        check("ld_rdata", {16'd0, data_rdata}, 32'h00AB);
        do_store(9'h015, 16'h1234);
        check("data_pc", {23'd0, pc}, 32'd2);

        // PC wrap and relative branch
        wait_cycles = 0;
        do_branch(2'b01, 16'h0000, 9'h1FF);
        check("abs_pc", {23'd0, pc}, 32'h1FF);
        do_fetch(16'hA1FF);
        check("wrap_pc", {23'd0, pc}, 32'd0);
        do_branch(2'b01, 16'h0000, 9'h005);
        do_branch(2'b00, 16'hFFFD, 9'h000);
        check("rel_pc", {23'd0, pc}, 32'd2);

        // Branch and fetch in the same cycle fetch from the new pc
        tick();
        br_take = 1'b1; br_mode = 2'b01; br_target = 9'h000; fetch_req = 1'b1;
        exp_ir_q.push_back(16'hD105);
        tick();
        br_take = 1'b0; fetch_req = 1'b0;
        wait_idle("brfetch_timeout");
        check("brfetch_pc", {23'd0, pc}, 32'd1);

        // Call / return
        do_branch(2'b01, 16'h0000, 9'd10);
        do_branch(2'b10, 16'd4, 9'h000);
        check("call_pc", {23'd0, pc}, 32'd14);
        do_branch(2'b11, 16'h0000, 9'h000);
        check("ret_pc", {23'd0, pc}, 32'd10);

        // Five nested calls then five returns
`ifdef FETCH_RAS_EN
        exp_ret[0] = 9'd14; exp_ret[1] = 9'd13; exp_ret[2] = 9'd12;
        exp_ret[3] = 9'd11; exp_ret[4] = 9'd0;
`else
        for (int k = 0; k < 5; k++) exp_ret[k] = 9'd14;
`endif
        for (int k = 0; k < 5; k++) do_branch(2'b10, 16'd1, 9'h000);
        check("nest_call_pc", {23'd0, pc}, 32'd15);
        for (int k = 0; k < 5; k++) begin
            do_branch(2'b11, 16'h0000, 9'h000);
            check("nest_ret_pc", {23'd0, pc}, {23'd0, exp_ret[k]});
        end

        // Reset during a stalled fetch aborts it
        do_branch(2'b01, 16'h0000, 9'h033);
        wait_cycles = 5;
        tick();
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        @(negedge clk);
        check("abort_cmd_pre", {30'd0, mem_cmd}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_cmd", {30'd0, mem_cmd}, 32'd0);
        check("abort_pc", {23'd0, pc}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        tick(); tick();
        reset = 1'b0;
        wait_cycles = 0;
        tick();
        check("abort_ir", {16'd0, ir}, 32'd0);

        // Halt wins over fetch_req; HALTED ignores everything
        halt = 1'b1; fetch_req = 1'b1;
        tick();
        halt = 1'b0;
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_cmd", {30'd0, mem_cmd}, 32'd0);
        br_take = 1'b1; br_mode = 2'b01; br_target = 9'h1FF;
        tick(); tick();
        check("halt_hold", {31'd0, halted}, 32'd1);
        check("halt_cmd2", {30'd0, mem_cmd}, 32'd0);
        check("halt_pc", {23'd0, pc}, 32'd0);
        check("halt_busy", {31'd0, busy}, 32'd0);
        fetch_req = 1'b0; br_take = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("halt_exit", {31'd0, halted}, 32'd0);
        tick();
        reset = 1'b0;
        tick(); tick();

        check("ir_q_empty", exp_ir_q.size(), 32'd0);
        check("data_q_empty", exp_data_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
